// File: rtl/transpose_scheduler.sv
// Round-robin scheduler sharing one 8x8 transpose engine among NUM_REQ requesters.
// One tile in flight; the granted tile and the engine result are buffered locally.
module transpose_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TILE_N  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  input  logic [NUM_REQ*TILE_N*DATA_W-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]                 o_resp_valid,
  input  logic [NUM_REQ-1:0]                 i_resp_ready,
  output logic [TILE_N*DATA_W-1:0]           o_resp_data,
  output logic                               o_eng_valid_in,
  input  logic                               i_eng_ready_in,
  output logic [TILE_N*DATA_W-1:0]           o_eng_data_in,
  input  logic                               i_eng_valid_out,
  output logic                               o_eng_ready_out,
  input  logic [TILE_N*DATA_W-1:0]           i_eng_data_out,
  output logic                               o_busy,
  output logic [2:0]                         o_owner,
  output logic                               o_timeout_err,
  input  logic                               i_err_clr,
  output logic [15:0]                        o_done_cnt
);

  localparam int unsigned TileW   = TILE_N * DATA_W;
  localparam logic [2:0]  LastReq = 3'(NUM_REQ - 1);
  localparam logic [15:0] WdogEnd = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              r_state, w_state_nxt;
  logic [2:0]          r_rr_ptr, w_rr_nxt;
  logic [2:0]          r_owner, w_owner_nxt, w_owner_inc;
  logic [15:0]         r_wdog, w_wdog_nxt;
  logic [15:0]         r_done_cnt, w_done_nxt;
  logic                r_timeout_err, w_timeout_nxt, w_timeout_hit;
  logic [TileW-1:0]    r_tile_buf, w_tile_nxt;
  logic [TileW-1:0]    r_resp_buf, w_resp_nxt;

  logic                w_grant_vld;
  logic [2:0]          w_grant;
  logic [NUM_REQ-1:0]  w_grant_oh, w_owner_oh, w_rot;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [TileW-1:0]    w_grant_tile;

  // Rotate the valid vector so bit i is requester (rr_ptr + i) mod NUM_REQ.
  assign w_dbl = {i_req_valid, i_req_valid} >> r_rr_ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];

  always_comb begin
    logic [3:0] sum;
    w_grant_vld  = 1'b0;
    w_grant      = '0;
    w_grant_oh   = '0;
    w_owner_oh   = '0;
    w_grant_tile = '0;
    sum          = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_grant_vld && w_rot[i]) begin
        w_grant_vld = 1'b1;
        sum         = {1'b0, r_rr_ptr} + 4'(i);
        w_grant     = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant == 3'(k)) begin
        w_grant_oh[k] = w_grant_vld;
        w_grant_tile  = i_req_data[k*TileW +: TileW];
      end
      w_owner_oh[k] = (r_owner == 3'(k));
    end
  end

  assign w_owner_inc = (r_owner == LastReq) ? 3'd0 : r_owner + 3'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_nxt        = r_rr_ptr;
    w_owner_nxt     = r_owner;
    w_wdog_nxt      = r_wdog;
    w_done_nxt      = r_done_cnt;
    w_tile_nxt      = r_tile_buf;
    w_resp_nxt      = r_resp_buf;
    w_timeout_hit   = 1'b0;
    o_req_ready     = '0;
    o_resp_valid    = '0;
    o_eng_valid_in  = 1'b0;
    o_eng_ready_out = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_grant_vld) begin
          o_req_ready = w_grant_oh;
          w_owner_nxt = w_grant;
          w_tile_nxt  = w_grant_tile;
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        o_eng_valid_in = 1'b1;
        if (i_eng_ready_in) begin
          w_wdog_nxt  = '0;
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        o_eng_ready_out = 1'b1;
        if (i_eng_valid_out) begin
          w_resp_nxt  = i_eng_data_out;
          w_state_nxt = StResp;
        end else if (r_wdog == WdogEnd) begin
          // Abort: drop the tile silently and move fairness past the owner.
          w_timeout_hit = 1'b1;
          w_rr_nxt      = w_owner_inc;
          w_state_nxt   = StIdle;
        end else begin
          w_wdog_nxt = r_wdog + 16'd1;
        end
      end
      StResp: begin
        o_resp_valid = w_owner_oh;
        if (|(i_resp_ready & w_owner_oh)) begin
          w_done_nxt  = r_done_cnt + 16'd1;
          w_rr_nxt    = w_owner_inc;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    w_timeout_nxt = w_timeout_hit | (r_timeout_err & ~i_err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_wdog        <= '0;
      r_done_cnt    <= '0;
      r_timeout_err <= 1'b0;
      r_tile_buf    <= '0;
      r_resp_buf    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_owner       <= w_owner_nxt;
      r_wdog        <= w_wdog_nxt;
      r_done_cnt    <= w_done_nxt;
      r_timeout_err <= w_timeout_nxt;
      r_tile_buf    <= w_tile_nxt;
      r_resp_buf    <= w_resp_nxt;
    end
  end

  assign o_eng_data_in = r_tile_buf;
  assign o_resp_data   = r_resp_buf;
  assign o_busy        = (r_state != StIdle);
  assign o_owner       = r_owner;
  assign o_timeout_err = r_timeout_err;
  assign o_done_cnt    = r_done_cnt;

endmodule

// File: tb/tb_transpose_scheduler.sv
// Directed + randomized bench for transpose_scheduler with a queue/arithmetic reference model.
module tb_transpose_scheduler;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int TN = 64;
  localparam int TO = 20;
  localparam int TW = TN * DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*TW-1:0]  req_data = '0;
  logic [NR-1:0]     resp_valid;
  logic [NR-1:0]     resp_ready = '0;
  logic [TW-1:0]     resp_data;
  logic              eng_valid_in;
  logic              eng_ready_in = 1'b0;
  logic [TW-1:0]     eng_data_in;
  logic              eng_valid_out = 1'b0;
  logic              eng_ready_out;
  logic [TW-1:0]     eng_data_out = '0;
  logic              busy;
  logic [2:0]        owner;
  logic              timeout_err;
  logic              err_clr = 1'b0;
  logic [15:0]       done_cnt;

  always #5 clk = ~clk;

  transpose_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .TILE_N(TN), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_data      (req_data),
    .o_resp_valid    (resp_valid),
    .i_resp_ready    (resp_ready),
    .o_resp_data     (resp_data),
    .o_eng_valid_in  (eng_valid_in),
    .i_eng_ready_in  (eng_ready_in),
    .o_eng_data_in   (eng_data_in),
    .i_eng_valid_out (eng_valid_out),
    .o_eng_ready_out (eng_ready_out),
    .i_eng_data_out  (eng_data_out),
    .o_busy          (busy),
    .o_owner         (owner),
    .o_timeout_err   (timeout_err),
    .i_err_clr       (err_clr),
    .o_done_cnt      (done_cnt)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_rr = 0;
  logic [15:0] m_done = '0;
  logic        m_err = 1'b0;
  int          grants[$];
  logic [TW-1:0] last_resp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_tile(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    int e;
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      e = 0;
      while (e < TN - 1 && obs[e*DW +: DW] === exp[e*DW +: DW]) e++;
      $error("FAIL %s elem %0d observed %0h expected %0h", tag, e, obs[e*DW +: DW],
             exp[e*DW +: DW]);
    end
  endtask

  function automatic logic [TW-1:0] transpose(input logic [TW-1:0] t);
    logic [TW-1:0] o;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        o[(j*8+i)*DW +: DW] = t[(i*8+j)*DW +: DW];
    return o;
  endfunction

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    for (int e = 0; e < TN; e++) t[e*DW +: DW] = 16'($urandom);
    return t;
  endfunction

  function automatic logic [NR-1:0] onehot(input int g);
    logic [NR-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Reference arbitration: first valid requester at or after the pointer, modulo NR.
  function automatic int model_grant();
    for (int i = 0; i < NR; i++)
      if (req_valid[(m_rr + i) % NR]) return (m_rr + i) % NR;
    return 0;
  endfunction

  task automatic randomize_data();
    for (int k = 0; k < NR; k++) req_data[k*TW +: TW] = rand_tile();
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_done = '0;
    m_err = 1'b0;
  endtask

  // mode 0: normal, 1: engine hangs (watchdog), 2: reset while waiting on the engine.
  task automatic do_txn(input int mode, input int in_stall, input int out_lat,
                        input int resp_stall);
    int            g, c;
    logic [TW-1:0] tile, exp;
    logic          ok, saw_resp;
    g = model_grant();
    c = 0;
    #1;
    while (req_ready == '0 && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    check("req_ready_grant", req_ready, onehot(g));
    tile = req_data[g*TW +: TW];
    exp  = transpose(tile);
    @(negedge clk);
    check("issue_valid", eng_valid_in, 1'b1);
    check("issue_owner", owner, g);
    check_tile("issue_data", eng_data_in, tile);
    grants.push_back(int'(owner));
    randomize_data();
    ok = 1'b1;
    repeat (in_stall) begin
      @(negedge clk);
      ok &= eng_valid_in && (eng_data_in === tile) && (req_ready == '0) && busy;
    end
    check("issue_hold", ok, 1'b1);
    eng_ready_in = 1'b1;
    @(negedge clk);
    eng_ready_in = 1'b0;
    check("wait_valid_in_low", {eng_valid_in, eng_ready_out}, 2'b01);
    if (mode == 1) begin
      c = 0;
      saw_resp = 1'b0;
      while (busy && c < 100) begin
        if (c == TO - 1) err_clr = 1'b1;
        @(negedge clk);
        saw_resp |= |resp_valid;
        c++;
      end
      err_clr = 1'b0;
      m_err = 1'b1;
      m_rr = (g + 1) % NR;
      check("timeout_cycles", c, TO);
      check("timeout_no_resp", saw_resp, 1'b0);
      check("timeout_err_set", timeout_err, m_err);
      return;
    end
    if (mode == 2) begin
      req_valid = '0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_hs", {req_ready, resp_valid, eng_valid_in, eng_ready_out}, '0);
      check("rst_regs", {owner, timeout_err, done_cnt}, '0);
      check_tile("rst_tile_buf", eng_data_in, '0);
      check_tile("rst_resp_buf", resp_data, '0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    ok = 1'b1;
    repeat (out_lat) begin
      @(negedge clk);
      ok &= eng_ready_out && (resp_valid == '0) && (eng_data_in === tile);
    end
    check("wait_hold", ok, 1'b1);
    eng_valid_out = 1'b1;
    eng_data_out  = exp;
    @(negedge clk);
    eng_valid_out = 1'b0;
    eng_data_out  = rand_tile();
    check("resp_valid", resp_valid, onehot(g));
    check_tile("resp_data", resp_data, exp);
    last_resp = resp_data;
    resp_ready = ~onehot(g);
    ok = 1'b1;
    repeat (resp_stall) begin
      @(negedge clk);
      ok &= (resp_valid == onehot(g)) && (resp_data === exp) && (req_ready == '0);
    end
    check("resp_hold", ok, 1'b1);
    resp_ready = onehot(g);
    @(negedge clk);
    resp_ready = '0;
    m_done = m_done + 16'd1;
    m_rr = (g + 1) % NR;
    check("done_cnt", done_cnt, m_done);
    check("idle_after", {busy, resp_valid}, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_order[5];
    int prev;
    exp_order = '{0, 1, 2, 3, 0};

    // Reset state
    randomize_data();
    @(negedge clk);
    check("reset_hs", {req_ready, resp_valid, eng_valid_in, eng_ready_out, busy}, '0);
    check("reset_regs", {owner, timeout_err, done_cnt}, '0);
    check_tile("reset_tile_buf", eng_data_in, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", {req_ready, busy}, '0);

    // Single request from requester 2, element i = i
    for (int e = 0; e < TN; e++) req_data[2*TW + e*DW +: DW] = 16'(e);
    req_valid = 4'b0100;
    do_txn(0, 0, 2, 0);
    check("single_elem8", last_resp[8*DW +: DW], 16'd1);
    check("single_done", done_cnt, 16'd1);
    req_valid = '0;

    // All requesters valid continuously from rr_ptr = 0
    do_reset();
    grants.delete();
    req_valid = 4'hF;
    for (int t = 0; t < 5; t++)
      do_txn(0, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
    for (int t = 0; t < 5; t++) check("rr_order", grants[t], exp_order[t]);
    check("rr_done5", done_cnt, 16'd5);

    // Backpressure on both engine input and response
    do_txn(0, 10, 1, 7);

    // Random masks and stalls
    for (int t = 0; t < 8; t++) begin
      req_valid = NR'($urandom_range(1, (1 << NR) - 1));
      do_txn(0, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3));
    end

    // Watchdog abort, then fairness moves past the aborted owner
    req_valid = 4'hF;
    do_txn(1, 0, 0, 0);
    prev = grants[grants.size() - 1];
    do_txn(0, 1, 2, 1);
    check("after_timeout_grant", grants[grants.size() - 1], (prev + 1) % NR);
    check("timeout_sticky", timeout_err, 1'b1);
    req_valid = '0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", timeout_err, 1'b0);

    // Reset while waiting on the engine
    req_valid = 4'b1000;
    do_txn(2, 0, 0, 0);
    req_valid = 4'hF;
    do_txn(0, 0, 1, 0);
    check("post_reset_grant", grants[grants.size() - 1], 0);
    req_valid = '0;

    // done_cnt wrap
    @(negedge clk);
    force dut.r_done_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_done_cnt;
    m_done = 16'hFFFF;
    #1;
    check("done_preload", done_cnt, 16'hFFFF);
    req_valid = 4'b0010;
    do_txn(0, 0, 1, 0);
    check("done_wrap", done_cnt, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
